// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and default frame geometry.
package uart_pkg;

   localparam int CLKS_PER_BIT_DEF = 16;
   localparam int DATA_WIDTH_DEF   = 8;
   // start + data + stop
   localparam int UART_FRAME_BITS  = DATA_WIDTH_DEF + 2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pin inputs; resets to 1 so idle-high lines
// do not look like an edge while reset is released.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 receive deserialiser: oversampled start detection, mid-bit sampling, sticky
// rxd_int / frame_err / overrun flags cleared by rxd_int_clr.
//
// state | meaning
// IDLE  | line idle, waiting for rxd_s low
// START | confirming start bit at half a bit period
// DATA  | sampling data bits LSB first, one per bit period
// STOP  | sampling stop bit, delivering byte or flagging error
// BREAK | frame error seen, waiting for line to return high
module uart_rx_deser
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int CNT_WIDTH    = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rxd,
   input  logic                  rxd_int_clr,
   output logic [DATA_WIDTH-1:0] r_data,
   output logic                  rxd_int,
   output logic                  frame_err,
   output logic                  overrun,
   output logic                  busy
);

   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_WIDTH-1:0] HALF_TC  = CNT_WIDTH'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_WIDTH-1:0] FULL_TC  = CNT_WIDTH'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DATA_WIDTH - 1);

   rx_state_e             state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  int_q, int_d;
   logic                  ferr_q, ferr_d;
   logic                  ovr_q, ovr_d;
   logic                  set_int, set_ferr, set_ovr;
   logic                  rxd_s;

   sync_2ff #(.WIDTH(1)) u_sync_rxd (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (rxd),
      .q_o   (rxd_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         int_q   <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         int_q   <= int_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      data_d   = data_q;
      set_int  = 1'b0;
      set_ferr = 1'b0;
      set_ovr  = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rxd_s) state_d = START;
         end
         START: begin
            if (cnt_q == HALF_TC) begin
               cnt_d = '0;
               idx_d = '0;
               state_d = rxd_s ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         DATA: begin
            if (cnt_q == FULL_TC) begin
               cnt_d   = '0;
               shift_d = {rxd_s, shift_q[DATA_WIDTH-1:1]};
               if (idx_q == LAST_IDX) state_d = STOP;
               else                   idx_d   = idx_q + IDX_W'(1);
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         STOP: begin
            if (cnt_q == FULL_TC) begin
               cnt_d = '0;
               if (rxd_s) begin
                  // a clear landing on the stop sample frees the buffer for this byte
                  if (!int_q || rxd_int_clr) begin
                     data_d  = shift_q;
                     set_int = 1'b1;
                  end else begin
                     set_ovr = 1'b1;
                  end
                  state_d = IDLE;
               end else begin
                  set_ferr = 1'b1;
                  state_d  = BREAK;
               end
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         BREAK: begin
            cnt_d = '0;
            if (rxd_s) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      int_d  = set_int  | (int_q  & ~rxd_int_clr);
      ferr_d = set_ferr | (ferr_q & ~rxd_int_clr);
      ovr_d  = set_ovr  | (ovr_q  & ~rxd_int_clr);
   end

   assign r_data    = data_q;
   assign rxd_int   = int_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser: frame-level reference model driven by the
// fixed start-edge-to-flag latency, plus directed latency and corner-case checks.
module tb_uart_rx_deser;
   import uart_pkg::*;

   localparam int CPB = 16;
   localparam int DW  = 8;
   localparam int LAT = 2 + CPB / 2 + (UART_FRAME_BITS - 1) * CPB + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rxd = 1'b1;
   logic          rxd_int_clr = 1'b0;
   logic [DW-1:0] r_data;
   logic          rxd_int, frame_err, overrun, busy;

   uart_rx_deser #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW), .CNT_WIDTH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rxd         (rxd),
      .rxd_int_clr (rxd_int_clr),
      .r_data      (r_data),
      .rxd_int     (rxd_int),
      .frame_err   (frame_err),
      .overrun     (overrun),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit cmp_en = 1'b0;
   bit rand_done = 1'b0;

   logic [DW-1:0] m_data = '0;
   logic          m_int = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;

   typedef struct {
      int            at;
      bit            ok;
      logic [DW-1:0] d;
   } ev_t;
   ev_t evq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Frame-level model: each frame resolves at a known cycle after its start edge.
   always @(posedge clk or negedge rst_n) begin : model
      ev_t           ev;
      bit            clr, s_int, s_ferr, s_ovr;
      logic [DW-1:0] nd;
      if (!rst_n) begin
         m_data = '0;
         m_int  = 1'b0;
         m_ferr = 1'b0;
         m_ovr  = 1'b0;
         evq.delete();
      end else begin
         cyc    = cyc + 1;
         clr    = rxd_int_clr;
         s_int  = 1'b0;
         s_ferr = 1'b0;
         s_ovr  = 1'b0;
         nd     = m_data;
         if (evq.size() > 0 && evq[0].at == cyc) begin
            ev = evq.pop_front();
            if (ev.ok) begin
               if (!m_int || clr) begin
                  nd    = ev.d;
                  s_int = 1'b1;
               end else begin
                  s_ovr = 1'b1;
               end
            end else begin
               s_ferr = 1'b1;
            end
         end
         m_data = nd;
         m_int  = s_int  || (m_int  && !clr);
         m_ferr = s_ferr || (m_ferr && !clr);
         m_ovr  = s_ovr  || (m_ovr  && !clr);
      end
   end

   always @(negedge clk) begin
      if (rst_n && cmp_en) begin
         chk("r_data", 32'(r_data), 32'(m_data));
         chk("rxd_int", 32'(rxd_int), 32'(m_int));
         chk("frame_err", 32'(frame_err), 32'(m_ferr));
         chk("overrun", 32'(overrun), 32'(m_ovr));
      end
   end

   task automatic send_frame(input logic [DW-1:0] d, input bit stop_ok, input int hold_bits);
      int c0;
      ev_t ev;
      @(posedge clk);
      #1 rxd = 1'b0;
      c0 = cyc;
      ev.at = c0 + LAT;
      ev.ok = stop_ok;
      ev.d  = d;
      evq.push_back(ev);
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < DW; i++) begin
         #1 rxd = d[i];
         repeat (CPB) @(posedge clk);
      end
      #1 rxd = stop_ok;
      repeat (CPB) @(posedge clk);
      if (!stop_ok) repeat (hold_bits * CPB) @(posedge clk);
      #1 rxd = 1'b1;
   endtask

   task automatic pulse_clr();
      @(posedge clk);
      #1 rxd_int_clr = 1'b1;
      @(posedge clk);
      #1 rxd_int_clr = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_r_data", 32'(r_data), 32'h0);
      chk("rst_rxd_int", 32'(rxd_int), 32'h0);
      chk("rst_frame_err", 32'(frame_err), 32'h0);
      chk("rst_overrun", 32'(overrun), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      rst_n  = 1'b1;
      cmp_en = 1'b1;
      repeat (5) @(posedge clk);

      // latency pin: flag must be low after edge 154 and high after edge 155
      fork
         send_frame(8'hA5, 1'b1, 0);
         begin
            @(posedge clk);
            repeat (154) @(posedge clk);
            #1 chk("lat_pre_int", 32'(rxd_int), 32'h0);
            chk("lat_pre_busy", 32'(busy), 32'h1);
            @(posedge clk);
            #1 chk("lat_int", 32'(rxd_int), 32'h1);
            chk("lat_data", 32'(r_data), 32'hA5);
            chk("lat_ferr", 32'(frame_err), 32'h0);
            chk("lat_busy", 32'(busy), 32'h0);
         end
      join
      pulse_clr();

      // glitch shorter than half a bit
      @(posedge clk);
      #1 rxd = 1'b0;
      repeat (5) @(posedge clk);
      #1 rxd = 1'b1;
      chk("glitch_busy", 32'(busy), 32'h1);
      n = 0;
      while (busy && n < 10) begin
         @(posedge clk);
         #1 n++;
      end
      chk("glitch_idle", 32'(busy), 32'h0);
      chk("glitch_data", 32'(r_data), 32'hA5);
      chk("glitch_int", 32'(rxd_int), 32'h0);

      // overrun
      send_frame(8'h3C, 1'b1, 0);
      send_frame(8'hF0, 1'b1, 0);
      chk("ovr_data", 32'(r_data), 32'h3C);
      chk("ovr_flag", 32'(overrun), 32'h1);
      chk("ovr_int", 32'(rxd_int), 32'h1);
      pulse_clr();
      chk("clr_int", 32'(rxd_int), 32'h0);
      chk("clr_ovr", 32'(overrun), 32'h0);
      chk("clr_ferr", 32'(frame_err), 32'h0);

      // clear coincides with stop sample: set wins, no overrun
      send_frame(8'h77, 1'b1, 0);
      fork
         send_frame(8'h12, 1'b1, 0);
         begin
            repeat (155) @(posedge clk);
            #1 rxd_int_clr = 1'b1;
            @(posedge clk);
            #1 rxd_int_clr = 1'b0;
         end
      join
      chk("coinc_int", 32'(rxd_int), 32'h1);
      chk("coinc_data", 32'(r_data), 32'h12);
      chk("coinc_ovr", 32'(overrun), 32'h0);
      pulse_clr();

      // framing error followed by a long break
      send_frame(8'h55, 1'b0, 40);
      chk("ferr_flag", 32'(frame_err), 32'h1);
      chk("ferr_int", 32'(rxd_int), 32'h0);
      chk("ferr_data", 32'(r_data), 32'h12);
      repeat (CPB) @(posedge clk);
      send_frame(8'h81, 1'b1, 0);
      chk("post_break_data", 32'(r_data), 32'h81);
      chk("post_break_int", 32'(rxd_int), 32'h1);

      // reset in the middle of the data bits of 0xFF
      @(posedge clk);
      #1 rxd = 1'b0;
      repeat (CPB) @(posedge clk);
      #1 rxd = 1'b1;
      repeat (3 * CPB) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_data", 32'(r_data), 32'h0);
      chk("midrst_int", 32'(rxd_int), 32'h0);
      chk("midrst_ferr", 32'(frame_err), 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (CPB) @(posedge clk);
      send_frame(8'h00, 1'b1, 0);
      chk("after_rst_int", 32'(rxd_int), 32'h1);
      chk("after_rst_data", 32'(r_data), 32'h00);
      chk("after_rst_busy", 32'(busy), 32'h0);
      pulse_clr();

      // randomized traffic with asynchronous clears
      fork
         begin
            for (int k = 0; k < 25; k++) begin
               logic [DW-1:0] d;
               bit            ok;
               int            gap;
               d   = DW'($urandom);
               ok  = ($urandom_range(0, 5) != 0);
               gap = $urandom_range(0, 20);
               send_frame(d, ok, $urandom_range(0, 3));
               if (!ok) gap = gap + CPB;
               repeat (gap) @(posedge clk);
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               repeat ($urandom_range(20, 400)) @(posedge clk);
               #1 rxd_int_clr = 1'b1;
               @(posedge clk);
               #1 rxd_int_clr = 1'b0;
            end
         end
      join
      repeat (4) @(posedge clk);
      #1;
      chk("final_busy", 32'(busy), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
Serial receive front end of the UART path. It deserialises 8N1 frames on rxd and presents each byte with a receive-interrupt flag to the SFR/TCON logic.
- r_data is loaded into SBUF.
- rxd_int drives TCON[4].
- The CPU clears the flag through rxd_int_clr, which is a pulse derived from a TCON[4] write of 0.
- Runs entirely in the MCU core clock domain; the bit rate comes from an internal divider.

Parameters:
CLKS_PER_BIT, 16, core clocks per serial bit; must be even and at least 4.
DATA_WIDTH, 8, data bits per frame, sent LSB first.
CNT_WIDTH, 8, width of the bit-period counter; must satisfy 2^CNT_WIDTH > CLKS_PER_BIT.

Ports:
clk  in  1  MCU core clock.
rst_n  in  1  asynchronous active-low reset; all flops clear immediately on assertion.
rxd  in  1  asynchronous serial input; idles high.
rxd_int_clr  in  1  one-cycle pulse that clears rxd_int, frame_err and overrun.
r_data  out  DATA_WIDTH  last correctly received byte.
rxd_int  out  1  sticky flag: a byte is valid in r_data.
frame_err  out  1  sticky flag: the stop bit was sampled low.
overrun  out  1  sticky flag: a byte completed while rxd_int was still set.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: r_data=0, rxd_int=0, frame_err=0, overrun=0, busy=0, state=IDLE, counters=0, synchroniser flops=1.
- Reset asserted mid-frame aborts the frame; no flag is set afterwards.
- Input synchronisation: rxd passes through a 2-flop synchroniser; rxd_s is its output. All decisions use rxd_s only.
- Bit counter cnt: increments every clk while busy. On reaching its target value it returns to 0 and generates a sample strobe.
- IDLE: when rxd_s==0, go to START with cnt=0.
- START: sample at cnt==CLKS_PER_BIT/2-1 (mid start bit).
  - rxd_s==1: false start, glitch rejected; return to IDLE with no flags.
  - rxd_s==0: go to DATA with bit index=0 and cnt=0.
- DATA: sample at cnt==CLKS_PER_BIT-1, i.e. the middle of each data bit. Shift rxd_s in LSB first. After DATA_WIDTH samples, go to STOP.
- STOP: sample at cnt==CLKS_PER_BIT-1.
  - rxd_s==1, valid stop:
    - If rxd_int==0 or rxd_int_clr is asserted in that same cycle: load r_data from the shift register and set rxd_int on the next edge.
    - Otherwise: keep the old r_data, discard the new byte, set overrun.
    - Either way, go to IDLE.
  - rxd_s==0: set frame_err, discard the byte (r_data and rxd_int unchanged), go to BREAK.
- BREAK: wait until rxd_s==1, then go to IDLE. This prevents a held-low line from being read as repeated frames.
- Latency: rxd_int rises exactly 2 + CLKS_PER_BIT/2 + (DATA_WIDTH+1)*CLKS_PER_BIT + 1 clocks after the falling start edge on rxd. This is 155 clocks at the default parameters.
- Back-to-back frames: a start edge is accepted on the first IDLE cycle after STOP. The receiver sits in IDLE for half a bit before the next start edge, which gives it margin against sender drift of up to ±4%.
- Flag clearing:
  - rxd_int_clr clears rxd_int, frame_err and overrun.
  - If a set and a clear occur in the same cycle, the set wins for that flag.
  - rxd_int_clr has no effect on the receive FSM.
- Width rules:
  - The shift register is exactly DATA_WIDTH wide.
  - The bit index counts 0..DATA_WIDTH-1 and needs no wrap beyond that range.
  - cnt never exceeds CLKS_PER_BIT-1.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding: IDLE=0, START=1, DATA=2, STOP=3, BREAK=4, in a 3-bit field;
  - the default constants for CLKS_PER_BIT and DATA_WIDTH;
  - the UART_FRAME_BITS constant, equal to DATA_WIDTH+2.
- Sub-module sync_2ff: a 2-flop synchroniser with reset value 1. It is reusable for the inti0/inti1 and cnt_0/cnt_1 pin inputs.

Test Plan:
- Reset then send 0xA5, with rxd_int_clr never asserted → r_data=0xA5 and rxd_int=1 exactly 155 clocks after the start edge; frame_err=0, busy=0 afterwards.
- Glitch: rxd low for 5 clocks, then high → stays in IDLE, busy back to 0 within 10 clocks, no flags, r_data unchanged.
- Send 0x3C with no clear, then 0xF0 → r_data=0x3C, overrun=1, rxd_int=1. Then pulse rxd_int_clr → all three flags are 0.
- Send a frame with the stop bit low and data 0x55, then hold rxd low for 40 bit periods → frame_err=1, rxd_int=0, r_data unchanged. After rxd goes high, 0x81 is received correctly.
- Assert rxd_int_clr in the exact cycle the stop sample of 0x12 succeeds while rxd_int=1 → rxd_int=1, r_data=0x12, overrun=0.
- Assert rst_n low mid-DATA of 0xFF → outputs reset immediately. After release, a following 0x00 frame is received correctly.
